// File: rtl/glogic_pkg.sv
// Shared types for the pipelined bitwise logic unit: opcode width and opcode enum.
package glogic_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND   = 3'd0,
    OP_OR    = 3'd1,
    OP_XOR   = 3'd2,
    OP_NAND  = 3'd3,
    OP_NOR   = 3'd4,
    OP_XNOR  = 3'd5,
    OP_NOTA  = 3'd6,
    OP_PASSA = 3'd7
  } op_e;

endpackage

// File: rtl/glogic_core.sv
// Combinational bitwise logic core: (op, a, b) -> (y, zr, ng), flags taken from the result.
module glogic_core
  import glogic_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             zr,
  output logic             ng
);

  // NOTE: y gets a default before the case so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    y = '0;
    case (op)
      OP_AND:   y = a & b;
      OP_OR:    y = a | b;
      OP_XOR:   y = a ^ b;
      OP_NAND:  y = ~(a & b);
      OP_NOR:   y = ~(a | b);
      OP_XNOR:  y = ~(a ^ b);
      OP_NOTA:  y = ~a;
      OP_PASSA: y = a;
      default:  y = '0;
    endcase
  end

  assign zr = (y == '0);
  assign ng = y[WIDTH-1];

endmodule

// File: rtl/glogic_pipe.sv
// Two-stage valid/ready pipeline around glogic_core; stage 1 holds operands, stage 2 holds result and flags.
module glogic_pipe
  import glogic_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  op_e              in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zr,
  output logic             out_ng
);

  logic             s1_valid;
  op_e              s1_op;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;

  logic             s2_valid;
  logic [WIDTH-1:0] s2_data;
  logic             s2_zr;
  logic             s2_ng;

  logic [WIDTH-1:0] core_y;
  logic             core_zr;
  logic             core_ng;

  logic adv1;
  logic adv2;

  // A stage may load when it is empty or its contents leave this cycle.
  assign adv2     = ~s2_valid | out_ready;
  assign adv1     = ~s1_valid | adv2;
  assign in_ready = adv1;

  glogic_core #(.WIDTH(WIDTH)) u_core (
    .op (s1_op),
    .a  (s1_a),
    .b  (s1_b),
    .y  (core_y),
    .zr (core_zr),
    .ng (core_ng)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_zr    <= 1'b0;
      s2_ng    <= 1'b0;
    end else begin
      if (adv1) s1_valid <= in_valid;
      if (adv2) s2_valid <= s1_valid;
      if (adv2 && s1_valid) begin
        s2_data <= core_y;
        s2_zr   <= core_zr;
        s2_ng   <= core_ng;
      end
    end
  end

  // NOTE: operand flops carry no reset; they are only observed while s1_valid marks them loaded.
  always_ff @(posedge clk) begin
    if (in_valid && adv1) begin
      s1_op <= in_op;
      s1_a  <= in_a;
      s1_b  <= in_b;
    end
  end

  assign out_valid = s2_valid;
  assign out_data  = s2_data;
  assign out_zr    = s2_zr;
  assign out_ng    = s2_ng;

endmodule

// File: tb/tb_glogic_pipe.sv
// Self-checking bench for glogic_pipe: directed ops, latency, back-pressure, throughput, random, reset, widths.
module tb_glogic_pipe;
  import glogic_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  op_e         in_op;
  logic [15:0] in_a, in_b;
  logic        out_valid, out_ready;
  logic [15:0] out_data;
  logic        out_zr, out_ng;

  logic        w_valid;
  op_e         w_op;
  logic [31:0] w_a, w_b;
  logic        in_ready8, out_valid8, zr8, ng8;
  logic [7:0]  out_data8;
  logic        in_ready32, out_valid32, zr32, ng32;
  logic [31:0] out_data32;

  always #5 clk = ~clk;

  glogic_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_zr(out_zr), .out_ng(out_ng)
  );

  glogic_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(w_valid), .in_ready(in_ready8), .in_op(w_op),
    .in_a(w_a[7:0]), .in_b(w_b[7:0]), .out_valid(out_valid8), .out_ready(1'b1),
    .out_data(out_data8), .out_zr(zr8), .out_ng(ng8)
  );

  glogic_pipe #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(w_valid), .in_ready(in_ready32), .in_op(w_op),
    .in_a(w_a), .in_b(w_b), .out_valid(out_valid32), .out_ready(1'b1),
    .out_data(out_data32), .out_zr(zr32), .out_ng(ng32)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int n_out = 0;
  int last_out_cyc = 0;
  logic acc;
  logic [33:0] next_exp;
  logic [33:0] q16[$];
  logic [33:0] q8[$];
  logic [33:0] q32[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: {zr, ng, result} of a w-bit bitwise op, straight from the opcode table.
  function automatic logic [33:0] ref_op(input int w, input logic [2:0] op,
                                         input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r, m;
    m = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    case (op)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: r = a ^ b;
      3'd3: r = ~(a & b);
      3'd4: r = ~(a | b);
      3'd5: r = ~(a ^ b);
      3'd6: r = ~a;
      default: r = a;
    endcase
    r = r & m;
    return {(r == 32'd0), r[w-1], r};
  endfunction

  // One clock cycle: sample handshakes away from the edge, score outputs, then advance to next negedge.
  task automatic step();
    logic [33:0] e;
    #1;
    acc = in_valid && in_ready;
    if (out_valid && out_ready) begin
      n_out++;
      last_out_cyc = cyc;
      if (q16.size() == 0) check("out16_unexpected", 1, 0);
      else begin
        e = q16.pop_front();
        check("out16", {out_zr, out_ng, 32'(out_data)}, e);
      end
    end
    if (acc) q16.push_back(next_exp);
    if (out_valid8) begin
      if (q8.size() == 0) check("out8_unexpected", 1, 0);
      else begin
        e = q8.pop_front();
        check("out8", {zr8, ng8, 32'(out_data8)}, e);
      end
    end
    if (w_valid && in_ready8) q8.push_back(ref_op(8, w_op, w_a, w_b));
    if (out_valid32) begin
      if (q32.size() == 0) check("out32_unexpected", 1, 0);
      else begin
        e = q32.pop_front();
        check("out32", {zr32, ng32, out_data32}, e);
      end
    end
    if (w_valid && in_ready32) q32.push_back(ref_op(32, w_op, w_a, w_b));
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain(input int n);
    in_valid = 1'b0;
    w_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (n) step();
  endtask

  typedef struct {
    op_e         op;
    logic [15:0] a;
    logic [15:0] b;
    logic [33:0] exp;
  } vec_t;

  initial begin
    vec_t vecs[8];
    int sent, guard, start, k;

    vecs[0] = '{OP_AND,   16'hF0F0, 16'h0FF0, {1'b0, 1'b0, 32'h0000_00F0}};
    vecs[1] = '{OP_OR,    16'hAAAA, 16'h5555, {1'b0, 1'b1, 32'h0000_FFFF}};
    vecs[2] = '{OP_XOR,   16'hBBBB, 16'hBBBB, {1'b1, 1'b0, 32'h0000_0000}};
    vecs[3] = '{OP_NAND,  16'h0000, 16'h0000, {1'b0, 1'b1, 32'h0000_FFFF}};
    vecs[4] = '{OP_NOTA,  16'h0000, 16'h1234, {1'b0, 1'b1, 32'h0000_FFFF}};
    vecs[5] = '{OP_PASSA, 16'h8001, 16'hFFFF, {1'b0, 1'b1, 32'h0000_8001}};
    vecs[6] = '{OP_NOR,   16'h0F0F, 16'hF000, {1'b0, 1'b0, 32'h0000_00F0}};
    vecs[7] = '{OP_XNOR,  16'h1234, 16'h1234, {1'b0, 1'b1, 32'h0000_FFFF}};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_op = OP_AND; in_a = '0; in_b = '0;
    w_valid = 1'b0; w_op = OP_AND; w_a = '0; w_b = '0; next_exp = '0;

    // Reset state.
    @(negedge clk); @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_flags", {out_zr, out_ng}, 0);
    check("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    #1 check("rel_in_ready", in_ready, 1);
    @(negedge clk);

    // Directed ops, one beat per cycle.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_op = vecs[i].op; in_a = vecs[i].a; in_b = vecs[i].b;
      next_exp = vecs[i].exp;
      step();
      check("ops_accept", acc, 1);
    end
    drain(4);
    check("ops_drained", q16.size(), 0);

    // Narrow and wide instances: ng must follow bit WIDTH-1.
    for (int i = 0; i < 16; i++) begin
      w_valid = 1'b1; w_op = op_e'(i % 8);
      w_a = $urandom; w_b = $urandom;
      if (i < 8) begin w_a[7] = 1'b1; w_a[31] = 1'b0; end
      else       begin w_a[7] = 1'b0; w_a[31] = 1'b1; end
      step();
    end
    drain(4);
    check("w8_drained", q8.size(), 0);
    check("w32_drained", q32.size(), 0);

    // Latency: single beat, out_valid only in cycle 2.
    for (k = 0; k < 5; k++) begin
      check($sformatf("lat_vld_c%0d", k), out_valid, (k == 2));
      in_valid = (k == 0); in_op = OP_XOR; in_a = 16'h00FF; in_b = 16'h0F0F;
      next_exp = ref_op(16, OP_XOR, 32'h00FF, 32'h0F0F);
      step();
    end

    // Back-pressure: 5 AND beats a=i b=FFFF, out_ready low for cycles 2-5.
    sent = 0; k = 0;
    while ((sent < 5 || q16.size() != 0) && k < 40) begin
      out_ready = !(k >= 2 && k <= 5);
      in_valid = (sent < 5); in_op = OP_AND; in_a = 16'(sent); in_b = 16'hFFFF;
      next_exp = ref_op(16, OP_AND, 32'(sent), 32'hFFFF);
      #1;
      if (k >= 2 && k <= 5) begin
        check($sformatf("bp_in_ready_c%0d", k), in_ready, 0);
        check($sformatf("bp_hold_c%0d", k), {out_valid, out_data}, {1'b1, 16'h0000});
      end
      step();
      if (acc) sent++;
      k++;
    end
    check("bp_done", {sent, q16.size()}, {32'd5, 32'd0});

    // Throughput: 100 back-to-back XOR beats.
    drain(2);
    n_out = 0; sent = 0; guard = 0; start = cyc;
    while (n_out < 100 && guard < 300) begin
      in_valid = (sent < 100); in_op = OP_XOR;
      in_a = 16'($urandom); in_b = 16'($urandom);
      next_exp = ref_op(16, OP_XOR, 32'(in_a), 32'(in_b));
      step();
      if (acc) sent++;
      guard++;
    end
    check("thru_count", n_out, 100);
    check("thru_cycles_in_range",
          ((last_out_cyc - start + 1) >= 101) && ((last_out_cyc - start + 1) <= 102), 1);

    // Random stimulus with 50% out_ready against the scoreboard.
    drain(3);
    in_valid = 1'b0; sent = 0; guard = 0;
    while ((sent < 1000 || q16.size() != 0) && guard < 20000) begin
      if (!in_valid && sent < 1000 && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1; in_op = op_e'($urandom_range(0, 7));
        in_a = 16'($urandom); in_b = 16'($urandom);
        next_exp = ref_op(16, in_op, 32'(in_a), 32'(in_b));
      end
      out_ready = ($urandom_range(0, 1) == 1);
      step();
      if (acc) begin sent++; in_valid = 1'b0; end
      guard++;
    end
    check("rand_done", {sent, q16.size()}, {32'd1000, 32'd0});

    // Reset mid-stream with both stages full.
    out_ready = 1'b0; sent = 0; guard = 0;
    while (sent < 2 && guard < 10) begin
      in_valid = 1'b1; in_op = OP_PASSA; in_a = 16'h1111 + 16'(sent); in_b = '0;
      next_exp = ref_op(16, OP_PASSA, 32'(in_a), 0);
      step();
      if (acc) sent++;
      guard++;
    end
    in_valid = 1'b0;
    check("mid_full", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_data", out_data, 0);
    check("mid_rst_in_ready", in_ready, 1);
    q16.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1; in_valid = 1'b1; in_op = OP_NOTA; in_a = 16'h5A5A; in_b = 16'hFFFF;
    next_exp = ref_op(16, OP_NOTA, 32'h5A5A, 32'hFFFF);
    n_out = 0;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    check("post_rst_one_out", n_out, 1);
    check("post_rst_drained", q16.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
